// File: rtl/seq_div_nbits_if.sv
// Handshake and operand bundle for the sequential divider.
// master = requester (control FSM), slave = divider.
interface seq_div_nbits_if #(
  parameter int width = 8
);
  logic             start_i;
  logic [width-1:0] a_i;
  logic [width-1:0] b_i;
  logic [width-1:0] q_o;
  logic [width-1:0] r_o;
  logic             busy_o;
  logic             done_o;
  logic             div0_o;

  modport master (
    output start_i, a_i, b_i,
    input  q_o, r_o, busy_o, done_o, div0_o
  );

  modport slave (
    input  start_i, a_i, b_i,
    output q_o, r_o, busy_o, done_o, div0_o
  );
endinterface

// File: rtl/seq_div_nbits.sv
// Unsigned restoring divider, one quotient bit per clock.
// start/busy/done handshake; divide-by-zero completes in one cycle.
module seq_div_nbits #(
  parameter int width = 8
) (
  input logic           clk_i,
  input logic           rst_i,
  seq_div_nbits_if.slave bus
);
  localparam int CW = (width > 2) ? $clog2(width) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q;
  logic [width-1:0] rem_q;
  logic [width-1:0] qsh_q;
  logic [width-1:0] div_q;
  logic [width-1:0] q_q;
  logic [width-1:0] r_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             div0_q;

  logic [width-1:0] low;
  logic [width:0]   trial;
  logic [width-1:0] rem_d;
  logic [width-1:0] qsh_d;
  logic             last;

  // rem always stays below div, so {rem, next dividend bit} fits width+1 bits
  always_comb begin
    low   = {rem_q[width-2:0], qsh_q[width-1]};
    trial = {rem_q[width-1], low} - {1'b0, div_q};
    rem_d = low;
    qsh_d = {qsh_q[width-2:0], 1'b0};
    if (!trial[width]) begin
      rem_d = trial[width-1:0];
      qsh_d = {qsh_q[width-2:0], 1'b1};
    end
    last = (cnt_q == CW'(width - 1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rem_q   <= '0;
      qsh_q   <= '0;
      div_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
          if (bus.start_i) begin
            qsh_q <= bus.a_i;
            div_q <= bus.b_i;
            rem_q <= '0;
            cnt_q <= '0;
            if (bus.b_i == '0) begin
              state_q <= DONE;
              q_q     <= '1;
              r_q     <= bus.a_i;
              div0_q  <= 1'b1;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= RUN;
              div0_q  <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          rem_q <= rem_d;
          qsh_q <= qsh_d;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            q_q     <= qsh_d;
            r_q     <= rem_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.q_o    = q_q;
  assign bus.r_o    = r_q;
  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
  assign bus.div0_o = div0_q;
endmodule

// File: tb/tb_seq_div_nbits.sv
// Directed and random checks of seq_div_nbits (width=8).
// Inputs driven and outputs sampled on the falling edge.
module tb_seq_div_nbits;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   ncmp = 0;
  int   nfail = 0;
  int   overlap = 0;

  seq_div_nbits_if #(.width(W)) dif ();

  seq_div_nbits #(.width(W)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (dif.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (dif.busy_o && dif.done_o) overlap++;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // pulse start for one edge; returns cycles to done and busy cycles
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int bc);
    dif.start_i = 1'b1;
    dif.a_i = a;
    dif.b_i = b;
    @(negedge clk);
    dif.start_i = 1'b0;
    dif.a_i = ~a;
    dif.b_i = ~b;
    lat = 0;
    bc = 0;
    while (!dif.done_o && lat < 40) begin
      bc += int'(dif.busy_o);
      @(negedge clk);
      lat++;
    end
  endtask

  vec_t vt[10];
  int lat, bc, n, dn;
  logic [W-1:0] ra, rb, eq, er;

  initial begin
    vt[0] = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0};
    vt[1] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
    vt[2] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
    vt[3] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
    vt[4] = '{8'd37,  8'd0,   8'hFF,  8'd37,  1'b1};
    vt[5] = '{8'd10,  8'd3,   8'd3,   8'd1,   1'b0};
    vt[6] = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
    vt[7] = '{8'd254, 8'd255, 8'd0,   8'd254, 1'b0};
    vt[8] = '{8'd128, 8'd2,   8'd64,  8'd0,   1'b0};
    vt[9] = '{8'd255, 8'd16,  8'd15,  8'd15,  1'b0};

    dif.start_i = 1'b0;
    dif.a_i = '0;
    dif.b_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(dif.busy_o), 0);
    chk("rst_done", int'(dif.done_o), 0);
    chk("rst_div0", int'(dif.div0_o), 0);
    chk("rst_q", int'(dif.q_o), 0);
    chk("rst_r", int'(dif.r_o), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_op(vt[i].a, vt[i].b, lat, bc);
      chk($sformatf("v%0d_lat", i), lat, vt[i].z ? 0 : W);
      chk($sformatf("v%0d_busy", i), bc, vt[i].z ? 0 : W);
      chk($sformatf("v%0d_q", i), int'(dif.q_o), int'(vt[i].q));
      chk($sformatf("v%0d_r", i), int'(dif.r_o), int'(vt[i].r));
      chk($sformatf("v%0d_div0", i), int'(dif.div0_o), int'(vt[i].z));
      @(negedge clk);
      chk($sformatf("v%0d_pulse", i), int'(dif.done_o), 0);
    end

    // start pulse mid-run is ignored
    dif.start_i = 1'b1;
    dif.a_i = 8'd100;
    dif.b_i = 8'd3;
    @(negedge clk);
    dif.start_i = 1'b0;
    n = 0;
    while (!dif.done_o && n < 40) begin
      if (n == 3) begin
        dif.start_i = 1'b1;
        dif.a_i = 8'd50;
        dif.b_i = 8'd5;
      end else begin
        dif.start_i = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    dif.start_i = 1'b0;
    chk("ign_lat", n, W);
    chk("ign_q", int'(dif.q_o), 33);
    chk("ign_r", int'(dif.r_o), 1);
    @(negedge clk);

    // reset mid-operation
    dif.start_i = 1'b1;
    dif.a_i = 8'd90;
    dif.b_i = 8'd4;
    @(negedge clk);
    dif.start_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_busy", int'(dif.busy_o), 0);
    chk("mrst_q", int'(dif.q_o), 0);
    chk("mrst_r", int'(dif.r_o), 0);
    dn = 0;
    repeat (12) begin
      dn += int'(dif.done_o);
      @(negedge clk);
    end
    chk("mrst_nodone", dn, 0);

    // back-to-back: new start during the DONE cycle
    run_op(8'd200, 8'd7, lat, bc);
    chk("b2b1_lat", lat, W);
    chk("b2b1_q", int'(dif.q_o), 28);
    chk("b2b1_r", int'(dif.r_o), 4);
    run_op(8'd60, 8'd7, lat, bc);
    chk("b2b2_lat", lat, W);
    chk("b2b2_q", int'(dif.q_o), 8);
    chk("b2b2_r", int'(dif.r_o), 4);
    @(negedge clk);

    // random pairs against a behavioural model
    for (int i = 0; i < 200; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
      eq = (rb == 0) ? '1 : ra / rb;
      er = (rb == 0) ? ra : ra % rb;
      run_op(ra, rb, lat, bc);
      ncmp++;
      if (lat != ((rb == 0) ? 0 : W) || dif.q_o != eq || dif.r_o != er ||
          dif.div0_o != (rb == 0)) begin
        nfail++;
        $display("FAIL rnd %0d/%0d: got q=%0d r=%0d z=%0d lat=%0d expected q=%0d r=%0d",
                 ra, rb, dif.q_o, dif.r_o, dif.div0_o, lat, eq, er);
      end
      if (i % 3 == 0) @(negedge clk);
    end

    chk("busy_done_excl", overlap, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
